// File: rtl/mem_responder_pkg.sv
// Shared types and default constants for the mem_responder memory model.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } port_e;

    localparam int DEF_AW       = 10;
    localparam int DEF_LATENCY  = 2;
    localparam int STARVE_LIMIT = 2;

endpackage

// File: rtl/mem_responder_ram.sv
// Word-addressed storage: synchronous write port, asynchronous read port.
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // NOTE: the array has no reset; clearing thousands of words is not a real
    // RAM behaviour, and contents are loaded from outside before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder shared by an instruction-fetch and a data port,
// with data-first arbitration, anti-starvation for fetch and a fixed latency.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    input  logic        end_i,
    output logic        idle_o
);

    localparam logic [3:0] CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    starve_q, starve_d;
    logic          halted_q;
    port_e         port_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   if_rdata_q, d_rdata_q;
    logic [31:0]   ram_rdata;
    logic          grant_if, grant_d;
    logic          resp;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{if_addr_i[31:AW+2], if_addr_i[1:0],
                                d_addr_i[31:AW+2], d_addr_i[1:0]};

    // Grants are combinational; gating with rst_n_i keeps them low during reset.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (rst_n_i && !halted_q && state_q == ST_IDLE) begin
            if (if_req_i && (!d_req_i || starve_q >= STARVE_MAX)) begin
                grant_if = 1'b1;
            end else if (d_req_i) begin
                grant_d = 1'b1;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if || grant_d) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                    if (grant_if || !if_req_i) begin
                        starve_d = 2'd0;
                    end else if (starve_q != 2'd3) begin
                        starve_d = starve_q + 2'd1;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            starve_q <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            halted_q <= halted_q | end_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            port_q  <= PORT_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (grant_if || grant_d) begin
            port_q  <= grant_d ? PORT_D : PORT_IF;
            we_q    <= grant_d & d_we_i;
            addr_q  <= grant_d ? d_addr_i[AW+1:2] : if_addr_i[AW+1:2];
            wdata_q <= d_wdata_i;
        end
    end

    assign resp = (state_q == ST_RESP);

    // Response data is presented live in RESP and held in these registers afterwards.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else if (resp) begin
            if (port_q == PORT_IF) begin
                if_rdata_q <= ram_rdata;
            end else begin
                d_rdata_q <= we_q ? wdata_q : ram_rdata;
            end
        end
    end

    mem_responder_ram #(
        .AW(AW)
    ) u_ram (
        .clk  (clk_i),
        .we   (resp && we_q),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign if_gnt_o    = grant_if;
    assign d_gnt_o     = grant_d;
    assign if_rvalid_o = resp && (port_q == PORT_IF);
    assign d_rvalid_o  = resp && (port_q == PORT_D);
    assign if_rdata_o  = if_rvalid_o ? ram_rdata : if_rdata_q;
    assign d_rdata_o   = d_rvalid_o ? (we_q ? wdata_q : ram_rdata) : d_rdata_q;
    assign idle_o      = halted_q && (state_q == ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (AW=10, LATENCY=2): hand-computed vectors
// for fetch, data, arbitration, wrap, halt and mid-access reset.
module tb_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'd0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = 32'd0;
    logic [31:0] d_wdata_i = 32'd0;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        end_i = 1'b0;
    logic        idle_o;

    int errors = 0;
    int checks = 0;

    mem_responder #(.AW(10), .LATENCY(2)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_gnt_o   (if_gnt_o),
        .if_rvalid_o(if_rvalid_o),
        .if_rdata_o (if_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .d_rdata_o  (d_rdata_o),
        .end_i      (end_i),
        .idle_o     (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, " if_gnt"}, if_gnt_o, 1'b0);
        check_bit({tag, " d_gnt"}, d_gnt_o, 1'b0);
        check_bit({tag, " if_rvalid"}, if_rvalid_o, 1'b0);
        check_bit({tag, " d_rvalid"}, d_rvalid_o, 1'b0);
        check({tag, " if_rdata"}, if_rdata_o, 32'd0);
        check({tag, " d_rdata"}, d_rdata_o, 32'd0);
        check_bit({tag, " idle"}, idle_o, 1'b0);
    endtask

    // One data access from an IDLE cycle: grant now, response two cycles later.
    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp, input string tag);
        d_req_i   = 1'b1;
        d_we_i    = we;
        d_addr_i  = addr;
        d_wdata_i = wdata;
        #1 check_bit({tag, " gnt"}, d_gnt_o, 1'b1);
        next_cycle();
        d_req_i = 1'b0;
        #1 check_bit({tag, " busy rvalid"}, d_rvalid_o, 1'b0);
        next_cycle();
        #1 check_bit({tag, " rvalid"}, d_rvalid_o, 1'b1);
        check({tag, " rdata"}, d_rdata_o, exp);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dut.u_ram.mem[2] = 32'h2222_2222;
        dut.u_ram.mem[4] = 32'hE000_0000;
        dut.u_ram.mem[5] = 32'h0000_0555;

        // Reset with both requests high: nothing may be granted.
        if_req_i = 1'b1;
        d_req_i  = 1'b1;
        next_cycle();
        #1 check_all_zero("reset");
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        next_cycle();
        rst_n_i = 1'b1;
        next_cycle();

        // Single fetch of word 4.
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        #1 check_bit("fetch gnt c0", if_gnt_o, 1'b1);
        check_bit("fetch no d_gnt c0", d_gnt_o, 1'b0);
        next_cycle();
        if_req_i = 1'b0;
        #1 check_bit("fetch rvalid c1", if_rvalid_o, 1'b0);
        next_cycle();
        #1 check_bit("fetch rvalid c2", if_rvalid_o, 1'b1);
        check("fetch rdata c2", if_rdata_o, 32'hE000_0000);
        check_bit("fetch no d_rvalid c2", d_rvalid_o, 1'b0);
        next_cycle();
        if_req_i  = 1'b1;
        if_addr_i = 32'h14;
        #1 check_bit("fetch rvalid c3", if_rvalid_o, 1'b0);
        check("fetch rdata hold c3", if_rdata_o, 32'hE000_0000);
        check_bit("fetch regrant c3", if_gnt_o, 1'b1);
        next_cycle();
        if_req_i = 1'b0;
        next_cycle();
        #1 check("fetch2 rdata", if_rdata_o, 32'h0000_0555);
        next_cycle();

        // Write then read back, sub-word offset ignored, address wrap.
        d_access(1'b1, 32'h20, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "wr 0x20");
        d_access(1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, "rd 0x20");
        d_access(1'b0, 32'h23, 32'h0, 32'hDEAD_BEEF, "rd 0x23");
        d_access(1'b1, 32'h0, 32'h5, 32'h5, "wr 0x0");
        d_access(1'b0, 32'h1000, 32'h0, 32'h5, "rd wrap 0x1000");

        // Both requesters held: grant order D, D, I, D, D, I.
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h20;
        for (int i = 0; i < 6; i++) begin
            logic is_d;
            is_d = (i % 3) != 2;
            #1 check_bit($sformatf("arb %0d d_gnt", i), d_gnt_o, is_d);
            check_bit($sformatf("arb %0d if_gnt", i), if_gnt_o, !is_d);
            next_cycle();
            #1 check_bit($sformatf("arb %0d busy gnt", i), d_gnt_o | if_gnt_o, 1'b0);
            next_cycle();
            #1 check_bit($sformatf("arb %0d d_rvalid", i), d_rvalid_o, is_d);
            check_bit($sformatf("arb %0d if_rvalid", i), if_rvalid_o, !is_d);
            next_cycle();
        end
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        next_cycle();

        // Program end while a fetch is in flight.
        if_req_i  = 1'b1;
        if_addr_i = 32'h14;
        #1 check_bit("end fetch gnt", if_gnt_o, 1'b1);
        next_cycle();
        if_req_i = 1'b0;
        end_i    = 1'b1;
        #1 check_bit("end idle busy", idle_o, 1'b0);
        next_cycle();
        end_i   = 1'b0;
        d_req_i = 1'b1;
        #1 check_bit("end rvalid", if_rvalid_o, 1'b1);
        check("end rdata", if_rdata_o, 32'h0000_0555);
        check_bit("end idle resp", idle_o, 1'b0);
        next_cycle();
        if_req_i = 1'b1;
        #1 check_bit("end idle after", idle_o, 1'b1);
        check_bit("end no d_gnt", d_gnt_o, 1'b0);
        check_bit("end no if_gnt", if_gnt_o, 1'b0);
        next_cycle();
        #1 check_bit("end still idle", idle_o, 1'b1);
        check_bit("end still no gnt", d_gnt_o | if_gnt_o, 1'b0);
        if_req_i = 1'b0;
        d_req_i  = 1'b0;

        // Fresh reset clears the halt, then reset lands in the middle of a write.
        rst_n_i = 1'b0;
        next_cycle();
        rst_n_i = 1'b1;
        next_cycle();
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h8;
        d_wdata_i = 32'h1;
        #1 check_bit("rst wr gnt", d_gnt_o, 1'b1);
        next_cycle();
        rst_n_i = 1'b0;
        #1 check_all_zero("rst busy");
        next_cycle();
        #1 check_all_zero("rst held");
        d_req_i = 1'b0;
        next_cycle();
        rst_n_i = 1'b1;
        #1 check_bit("rst after d_rvalid", d_rvalid_o, 1'b0);
        next_cycle();
        #1 check_bit("rst after2 d_rvalid", d_rvalid_o, 1'b0);
        d_access(1'b0, 32'h8, 32'h0, 32'h2222_2222, "rst rd 0x8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
